// File: rtl/serial_mux_scanner_if.sv
// Handshake and mux-side bus for serial_mux_scanner: word input, held word/select
// toward the 16:1 mux, and the framed serial beat stream.
interface serial_mux_scanner_if #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_hold;
  logic [SEL_W-1:0] sel;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_first;
  logic             ser_last;
  logic             busy;

  modport master (
    output in_data, in_valid, ser_ready,
    input  in_ready, data_hold, sel, ser_out, ser_valid, ser_first, ser_last, busy
  );

  modport slave (
    input  in_data, in_valid, ser_ready,
    output in_ready, data_hold, sel, ser_out, ser_valid, ser_first, ser_last, busy
  );
endinterface

// File: rtl/serial_mux_scanner.sv
// Parallel-to-serial scanner driving a WIDTH:1 mux (held word + select), LSB first.
// Optional trailing even-parity beat when SCAN_PARITY_EN is defined.
module serial_mux_scanner #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
) (
  input logic                clk,
  input logic                rst_n,
  serial_mux_scanner_if.slave bus
);

  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] hold;
  logic [SEL_W-1:0] sel;
  logic             armed;

  logic in_shift;
  logic at_top;
  logic last_beat;
  logic beat_ok;
  logic load;

  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction

  assign in_shift = (state == SHIFT);
  assign at_top   = (sel == SEL_MAX);

`ifdef SCAN_PARITY_EN
  assign last_beat = (state == PARITY);
`else
  assign last_beat = in_shift && at_top;
`endif

  assign beat_ok = (state != IDLE) && bus.ser_ready;

  // armed keeps in_ready low while reset is held, then opens IDLE acceptance.
  assign bus.in_ready = ((state == IDLE) && armed) || (last_beat && bus.ser_ready);
  assign load         = bus.in_valid && bus.in_ready;

  assign bus.data_hold = hold;
  assign bus.sel       = sel;
  assign bus.ser_valid = (state != IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.ser_first = in_shift && (sel == '0);
  assign bus.ser_last  = last_beat;

`ifdef SCAN_PARITY_EN
  assign bus.ser_out = (state == PARITY) ? even_parity(hold) : hold[sel];
`else
  assign bus.ser_out = hold[sel];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hold  <= '0;
      sel   <= '0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (load) begin
        // Covers both a load from IDLE and a back-to-back reload on the last beat.
        hold  <= bus.in_data;
        sel   <= '0;
        state <= SHIFT;
      end else begin
        case (state)
          IDLE: begin
            sel <= sel;
          end
          SHIFT: begin
            if (beat_ok) begin
              if (!at_top) begin
                sel <= sel + 1'b1;
              end else begin
`ifdef SCAN_PARITY_EN
                state <= PARITY;
`else
                state <= IDLE;
                sel   <= '0;
`endif
              end
            end
          end
`ifdef SCAN_PARITY_EN
          PARITY: begin
            if (beat_ok) begin
              state <= IDLE;
              sel   <= '0;
            end
          end
`endif
          default: begin
            state <= IDLE;
            sel   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_mux_scanner.sv
// Directed + randomized bench for serial_mux_scanner against a frame-level model
// (bit k of the word, then optional even parity under SCAN_PARITY_EN).
module tb_serial_mux_scanner;

  localparam int W  = 16;
  localparam int SW = 4;
`ifdef SCAN_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  serial_mux_scanner_if #(.WIDTH(W), .SEL_W(SW)) bus ();

  serial_mux_scanner #(.WIDTH(W), .SEL_W(SW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Beat k of a frame: word bit k for k < W, else the even-parity bit.
  function automatic logic model_bit(input logic [15:0] w, input int k);
    logic [15:0] s;
    if (k < W) begin
      s = w >> k;
      return s[0];
    end
    return ($countones(w) % 2) == 1;
  endfunction

  task automatic check_beat(input string tag, input logic [15:0] w, input int k);
    int sel_exp;
    sel_exp = (k < W) ? k : W - 1;
    chk({tag, "_valid"}, bus.ser_valid, 1);
    chk({tag, "_busy"},  bus.busy, 1);
    chk({tag, "_out"},   bus.ser_out, model_bit(w, k));
    chk({tag, "_first"}, bus.ser_first, (k == 0));
    chk({tag, "_last"},  bus.ser_last, (k == FL - 1));
    chk({tag, "_sel"},   bus.sel, sel_exp);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"},  bus.in_ready, 0);
    chk({tag, "_ser_valid"}, bus.ser_valid, 0);
    chk({tag, "_busy"},      bus.busy, 0);
    chk({tag, "_sel"},       bus.sel, 0);
    chk({tag, "_hold"},      bus.data_hold, 0);
    chk({tag, "_ser_out"},   bus.ser_out, 0);
    chk({tag, "_first"},     bus.ser_first, 0);
    chk({tag, "_last"},      bus.ser_last, 0);
  endtask

  task automatic load(input logic [15:0] w);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    #1;
    chk("load_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = 16'($urandom);
  endtask

  // Walk one frame from beat 0 (visible now). Optional forced stall, random stalls,
  // junk in_valid on a mid beat, mid-frame reset, and back-to-back chaining.
  task automatic play(input logic [15:0] w, input int stall_rate, input int stall_at,
                      input int stall_len, input int abort_at, input bit chain,
                      input logic [15:0] nxt, input int junk_at);
    for (int k = 0; k < FL; k++) begin
      int stalls;
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        return;
      end
      if (k == stall_at) stalls = stall_len;
      else if ($urandom_range(99) < stall_rate) stalls = $urandom_range(3, 1);
      else stalls = 0;
      bus.ser_ready = 1'b0;
      for (int s = 0; s < stalls; s++) begin
        #1;
        check_beat("stall", w, k);
        chk("stall_in_ready", bus.in_ready, 0);
        step();
      end
      bus.ser_ready = 1'b1;
      if (k != FL - 1 && (k == junk_at || $urandom_range(3) == 0)) begin
        bus.in_valid = 1'b1;
        bus.in_data  = ~w;
      end
      if (k == FL - 1 && chain) begin
        bus.in_valid = 1'b1;
        bus.in_data  = nxt;
      end
      #1;
      check_beat("beat", w, k);
      chk("beat_in_ready", bus.in_ready, (k == FL - 1));
      step();
      bus.in_valid = 1'b0;
      if (k < FL - 1) chk("hold_kept", bus.data_hold, w);
    end
    if (chain) begin
      chk("chain_hold", bus.data_hold, nxt);
    end else begin
      chk("end_busy", bus.busy, 0);
      chk("end_ser_valid", bus.ser_valid, 0);
      chk("end_in_ready", bus.in_ready, 1);
      chk("end_sel", bus.sel, 0);
      chk("end_hold", bus.data_hold, w);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] w;
    logic [15:0] nxt;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.ser_ready = 1'b0;

    #2 rst_n = 1'b0;
    #2 check_zero("reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("idle_in_ready", bus.in_ready, 1);
    chk("idle_busy", bus.busy, 0);
    bus.ser_ready = 1'b1;

    load(16'h2b8d);
    play(16'h2b8d, 0, -1, 0, -1, 1'b0, 16'h0, -1);

    load(16'h0001);
    play(16'h0001, 0, 5, 3, -1, 1'b0, 16'h0, 7);

    load(16'hffff);
    play(16'hffff, 0, -1, 0, -1, 1'b1, 16'h0000, -1);
    play(16'h0000, 0, -1, 0, -1, 1'b0, 16'h0, -1);

    w = 16'($urandom);
    load(w);
    play(w, 0, -1, 0, 9, 1'b0, 16'h0, -1);
    step();
    check_zero("rst_hold");
    rst_n = 1'b1;
    step();
    chk("rel_in_ready", bus.in_ready, 1);
    chk("rel_busy", bus.busy, 0);
    chk("rel_ser_valid", bus.ser_valid, 0);

    for (int r = 0; r < 8; r++) begin
      w = 16'($urandom);
      load(w);
      for (int j = 0; j < 3; j++) begin
        nxt = 16'($urandom);
        play(w, 25, -1, 0, -1, (j < 2), nxt, -1);
        w = nxt;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
